// File: rtl/writeback_stage.sv
// Writeback stage: selects the load or ALU result from the MEM/WB bundle and
// retires it either as one scalar register-file write or as a sequence of
// lane writes into the vector register file. Also provides a forwarding tap
// and a retired-instruction counter.
module writeback_stage #(
    parameter int BUFFER_SIZE = 302,
    parameter int VEC_W       = 144,
    parameter int LANE_W      = 24,
    parameter int LANES       = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [BUFFER_SIZE-1:0] bufferIn,
    input  logic                   inValid,
    output logic                   inReady,
    output logic                   rfWe,
    output logic [3:0]             rfWa,
    output logic [LANE_W-1:0]      rfWd,
    output logic                   vrfWe,
    output logic [3:0]             vrfWa,
    output logic [2:0]             vrfLane,
    output logic [LANE_W-1:0]      vrfWd,
    output logic                   fwdValid,
    output logic                   fwdVector,
    output logic [3:0]             fwdRc,
    output logic [VEC_W-1:0]       fwdData,
    output logic [15:0]            retiredCount
);

    // Bundle field positions
    localparam int BIT_REGWRITEV = 301;
    localparam int BIT_MEMTOREG  = 293;
    localparam int BIT_REGWRITE  = 292;
    localparam int RC_LSB        = 288;
    localparam int QA_LSB        = 144;
    localparam int A1_LSB        = 0;
    localparam logic [2:0] LAST_LANE = 3'(LANES - 1);

    typedef enum logic {IDLE = 1'b0, VEC = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        lane_reg, lane_next;
    logic [6:0]        opmeta_unused_reg;

    logic              accept;
    logic              is_vec, is_scalar, writes;
    logic [3:0]        rc_in;
    logic [VEC_W-1:0]  qa_in, a1_in, result;
    logic [LANE_W-1:0] lane_w [LANES];

    assign rc_in     = bufferIn[RC_LSB +: 4];
    assign qa_in     = bufferIn[QA_LSB +: VEC_W];
    assign a1_in     = bufferIn[A1_LSB +: VEC_W];
    assign result    = bufferIn[BIT_MEMTOREG] ? qa_in : a1_in;
    assign is_vec    = bufferIn[BIT_REGWRITEV];
    // A vector write takes priority; the scalar flag is ignored alongside it
    assign is_scalar = ~bufferIn[BIT_REGWRITEV] & bufferIn[BIT_REGWRITE];
    assign writes    = is_vec | is_scalar;

    // Ready only when idle and out of reset
    assign inReady = (state_reg == IDLE) & rst;
    assign accept  = inValid & inReady & en;

    // Split the captured result into lane words
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_w[gi] = fwdData[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // State and lane counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            lane_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
        end
    end

    // Next-state logic: a vector accept walks lanes 0..LANES-1 while en is high
    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        case (state_reg)
            IDLE: begin
                if (accept && is_vec) begin
                    state_next = VEC;
                    lane_next  = 3'd0;
                end
            end
            VEC: begin
                if (en) begin
                    if (lane_reg == LAST_LANE) begin
                        state_next = IDLE;
                        lane_next  = 3'd0;
                    end else begin
                        lane_next = lane_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                lane_next  = 3'd0;
            end
        endcase
    end

    // Vector write port outputs, driven from the current state and lane
    always_comb begin
        vrfWe   = (state_reg == VEC) & en;
        vrfWa   = fwdRc;
        vrfLane = lane_reg;
        vrfWd   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_reg == 3'(i)) vrfWd = lane_w[i];
        end
    end

    // Scalar write port: one registered pulse the cycle after a scalar accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rfWe <= 1'b0;
            rfWa <= 4'd0;
            rfWd <= '0;
        end else begin
            rfWe <= accept & is_scalar;
            if (accept && is_scalar) begin
                rfWa <= rc_in;
                rfWd <= result[LANE_W-1:0];
            end
        end
    end

    // Forwarding tap: valid from accept until the final write pulse completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwdValid  <= 1'b0;
            fwdVector <= 1'b0;
            fwdRc     <= 4'd0;
            fwdData   <= '0;
        end else begin
            if (accept && writes) begin
                fwdValid  <= 1'b1;
                fwdVector <= is_vec;
                fwdRc     <= rc_in;
                fwdData   <= result;
            end else if (state_reg == IDLE) begin
                fwdValid <= 1'b0;
            end else if (en && lane_reg == LAST_LANE) begin
                fwdValid <= 1'b0;
            end
        end
    end

    // Retire counter and capture of the decoded-but-unused opcode fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retiredCount      <= 16'd0;
            opmeta_unused_reg <= 7'd0;
        end else if (accept) begin
            retiredCount      <= retiredCount + 16'd1;
            opmeta_unused_reg <= bufferIn[300:294];
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage.
module tb_writeback_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [301:0] bufferIn;
    logic         inValid;
    logic         inReady;
    logic         rfWe;
    logic [3:0]   rfWa;
    logic [23:0]  rfWd;
    logic         vrfWe;
    logic [3:0]   vrfWa;
    logic [2:0]   vrfLane;
    logic [23:0]  vrfWd;
    logic         fwdValid;
    logic         fwdVector;
    logic [3:0]   fwdRc;
    logic [143:0] fwdData;
    logic [15:0]  retiredCount;

    int tests_run = 0;
    int tests_failed = 0;

    writeback_stage dut (
        .clk(clk), .rst(rst), .en(en), .bufferIn(bufferIn), .inValid(inValid),
        .inReady(inReady), .rfWe(rfWe), .rfWa(rfWa), .rfWd(rfWd),
        .vrfWe(vrfWe), .vrfWa(vrfWa), .vrfLane(vrfLane), .vrfWd(vrfWd),
        .fwdValid(fwdValid), .fwdVector(fwdVector), .fwdRc(fwdRc),
        .fwdData(fwdData), .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    function automatic logic [301:0] mk(input logic v, input logic m2r, input logic rw,
                                        input logic [3:0] rc, input logic [143:0] qa,
                                        input logic [143:0] a1);
        return {v, 1'b0, 2'b00, 4'h0, m2r, rw, rc, qa, a1};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b1; inValid = 1'b0; bufferIn = '0;
        #2;
        tests_run++;
        if (inReady !== 1'b0) begin tests_failed++; $display("FAIL reset_inready got=%0b exp=0", inReady); end
        tests_run++;
        if (rfWe !== 1'b0 || vrfWe !== 1'b0 || fwdValid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_we got rfWe=%0b vrfWe=%0b fwdValid=%0b exp=0", rfWe, vrfWe, fwdValid);
        end
        tests_run++;
        if (retiredCount !== 16'd0) begin tests_failed++; $display("FAIL reset_count got=%0h exp=0", retiredCount); end
        step; step;
        rst = 1'b1;
        #1;
        tests_run++;
        if (inReady !== 1'b1) begin tests_failed++; $display("FAIL reset_release_inready got=%0b exp=1", inReady); end
        $display("[TB] reset done");
    endtask

    task automatic test_scalar_alu;
        bufferIn = mk(1'b0, 1'b0, 1'b1, 4'd3, 144'd0, 144'h00ABCD);
        inValid = 1'b1;
        step;
        inValid = 1'b0;
        tests_run++;
        if (rfWe !== 1'b1 || rfWa !== 4'd3 || rfWd !== 24'h00ABCD) begin
            tests_failed++; $display("FAIL scalar_alu got we=%0b wa=%0d wd=%h exp we=1 wa=3 wd=00abcd", rfWe, rfWa, rfWd);
        end
        tests_run++;
        if (retiredCount !== 16'd1) begin tests_failed++; $display("FAIL scalar_alu_count got=%0d exp=1", retiredCount); end
        tests_run++;
        if (fwdValid !== 1'b1 || fwdVector !== 1'b0 || fwdRc !== 4'd3) begin
            tests_failed++; $display("FAIL scalar_alu_fwd got v=%0b vec=%0b rc=%0d exp v=1 vec=0 rc=3", fwdValid, fwdVector, fwdRc);
        end
        step;
        tests_run++;
        if (rfWe !== 1'b0 || fwdValid !== 1'b0 || fwdRc !== 4'd3) begin
            tests_failed++; $display("FAIL scalar_alu_after got we=%0b fv=%0b rc=%0d exp we=0 fv=0 rc=3", rfWe, fwdValid, fwdRc);
        end
        $display("[TB] scalar alu transaction rc=3 wd=%h", rfWd);
    endtask

    task automatic test_back_to_back;
        logic [3:0]  rcs [3];
        logic [23:0] ds  [3];
        rcs[0] = 4'd1; rcs[1] = 4'd2; rcs[2] = 4'd4;
        ds[0] = 24'h123456; ds[1] = 24'h111111; ds[2] = 24'h222222;
        bufferIn = mk(1'b0, 1'b1, 1'b1, rcs[0], {120'd0, ds[0]}, 144'd0);
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            tests_run++;
            if (rfWe !== 1'b1 || rfWa !== rcs[i] || rfWd !== ds[i] || inReady !== 1'b1) begin
                tests_failed++;
                $display("FAIL load_b2b_%0d got we=%0b wa=%0d wd=%h rdy=%0b exp we=1 wa=%0d wd=%h rdy=1",
                         i, rfWe, rfWa, rfWd, inReady, rcs[i], ds[i]);
            end
            $display("[TB] load transaction %0d rc=%0d wd=%h", i, rfWa, rfWd);
            if (i < 2) bufferIn = mk(1'b0, 1'b1, 1'b1, rcs[i+1], {120'd0, ds[i+1]}, 144'd0);
            else inValid = 1'b0;
        end
        step;
        tests_run++;
        if (rfWe !== 1'b0 || retiredCount !== 16'd4) begin
            tests_failed++; $display("FAIL load_b2b_end got we=%0b cnt=%0d exp we=0 cnt=4", rfWe, retiredCount);
        end
    endtask

    task automatic test_vector;
        logic [143:0] qa;
        for (int k = 0; k < 6; k++) qa[k*24 +: 24] = 24'(k + 1);
        bufferIn = mk(1'b1, 1'b1, 1'b0, 4'd7, qa, 144'd0);
        inValid = 1'b1;
        step;
        inValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (vrfWe !== 1'b1 || vrfLane !== 3'(k) || vrfWd !== 24'(k + 1) || vrfWa !== 4'd7 ||
                inReady !== 1'b0 || fwdValid !== 1'b1 || fwdVector !== 1'b1 || rfWe !== 1'b0) begin
                tests_failed++;
                $display("FAIL vector_lane_%0d got we=%0b lane=%0d wd=%h wa=%0d rdy=%0b fv=%0b fvec=%0b rfwe=%0b exp we=1 lane=%0d wd=%h wa=7 rdy=0 fv=1 fvec=1 rfwe=0",
                         k, vrfWe, vrfLane, vrfWd, vrfWa, inReady, fwdValid, fwdVector, rfWe, k, 24'(k + 1));
            end
            $display("[TB] vector lane write lane=%0d wd=%h", vrfLane, vrfWd);
            step;
        end
        tests_run++;
        if (vrfWe !== 1'b0 || inReady !== 1'b1 || fwdValid !== 1'b0 || retiredCount !== 16'd5) begin
            tests_failed++;
            $display("FAIL vector_end got we=%0b rdy=%0b fv=%0b cnt=%0d exp we=0 rdy=1 fv=0 cnt=5", vrfWe, inReady, fwdValid, retiredCount);
        end
    endtask

    task automatic test_stall;
        logic [143:0] qa;
        for (int k = 0; k < 6; k++) qa[k*24 +: 24] = 24'(16 + k);
        bufferIn = mk(1'b1, 1'b1, 1'b0, 4'd9, qa, 144'd0);
        inValid = 1'b1;
        step;
        inValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (vrfWe !== 1'b1 || vrfLane !== 3'(k) || vrfWd !== 24'(16 + k)) begin
                tests_failed++; $display("FAIL stall_pre_%0d got we=%0b lane=%0d wd=%h exp we=1 lane=%0d wd=%h", k, vrfWe, vrfLane, vrfWd, k, 24'(16 + k));
            end
            step;
        end
        en = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            tests_run++;
            if (vrfWe !== 1'b0 || vrfLane !== 3'd3 || fwdValid !== 1'b1 || inReady !== 1'b0) begin
                tests_failed++; $display("FAIL stall_hold_%0d got we=%0b lane=%0d fv=%0b rdy=%0b exp we=0 lane=3 fv=1 rdy=0", s, vrfWe, vrfLane, fwdValid, inReady);
            end
            step;
        end
        en = 1'b1;
        #1;
        for (int k = 3; k < 6; k++) begin
            tests_run++;
            if (vrfWe !== 1'b1 || vrfLane !== 3'(k) || vrfWd !== 24'(16 + k) || vrfWa !== 4'd9) begin
                tests_failed++; $display("FAIL stall_post_%0d got we=%0b lane=%0d wd=%h wa=%0d exp we=1 lane=%0d wd=%h wa=9", k, vrfWe, vrfLane, vrfWd, vrfWa, k, 24'(16 + k));
            end
            $display("[TB] stalled vector lane write lane=%0d wd=%h", vrfLane, vrfWd);
            step;
        end
        tests_run++;
        if (vrfWe !== 1'b0 || inReady !== 1'b1 || retiredCount !== 16'd6) begin
            tests_failed++; $display("FAIL stall_end got we=%0b rdy=%0b cnt=%0d exp we=0 rdy=1 cnt=6", vrfWe, inReady, retiredCount);
        end
    endtask

    task automatic test_both_flags_and_store;
        logic [143:0] a1;
        for (int k = 0; k < 6; k++) a1[k*24 +: 24] = 24'(160 + k);
        bufferIn = mk(1'b1, 1'b0, 1'b1, 4'd5, {144{1'b1}}, a1);
        inValid = 1'b1;
        step;
        inValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (rfWe !== 1'b0 || vrfWe !== 1'b1 || vrfWd !== 24'(160 + k) || vrfWa !== 4'd5) begin
                tests_failed++; $display("FAIL both_flags_%0d got rfwe=%0b vwe=%0b wd=%h wa=%0d exp rfwe=0 vwe=1 wd=%h wa=5", k, rfWe, vrfWe, vrfWd, vrfWa, 24'(160 + k));
            end
            step;
        end
        $display("[TB] both-flags vector transaction rc=5");
        bufferIn = mk(1'b0, 1'b1, 1'b0, 4'd6, 144'd0, 144'd0);
        inValid = 1'b1;
        step;
        inValid = 1'b0;
        tests_run++;
        if (rfWe !== 1'b0 || vrfWe !== 1'b0 || fwdValid !== 1'b0 || fwdRc !== 4'd5 || retiredCount !== 16'd8) begin
            tests_failed++; $display("FAIL store_nop got rfwe=%0b vwe=%0b fv=%0b rc=%0d cnt=%0d exp rfwe=0 vwe=0 fv=0 rc=5 cnt=8",
                                     rfWe, vrfWe, fwdValid, fwdRc, retiredCount);
        end
        $display("[TB] store transaction cnt=%0d", retiredCount);
    endtask

    task automatic test_reset_mid_vector;
        logic [143:0] qa;
        logic         seen;
        for (int k = 0; k < 6; k++) qa[k*24 +: 24] = 24'(32 + k);
        bufferIn = mk(1'b1, 1'b1, 1'b0, 4'd2, qa, 144'd0);
        inValid = 1'b1;
        step;
        inValid = 1'b0;
        step; step;
        tests_run++;
        if (vrfLane !== 3'd2 || vrfWe !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_pre got lane=%0d we=%0b exp lane=2 we=1", vrfLane, vrfWe);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (vrfWe !== 1'b0 || rfWe !== 1'b0 || fwdValid !== 1'b0 || retiredCount !== 16'd0 ||
            fwdData !== 144'd0 || vrfWd !== 24'd0 || inReady !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_outputs got vwe=%0b rfwe=%0b fv=%0b cnt=%0d wd=%h rdy=%0b exp all 0",
                                     vrfWe, rfWe, fwdValid, retiredCount, vrfWd, inReady);
        end
        step;
        rst = 1'b1;
        #1;
        tests_run++;
        if (inReady !== 1'b1 || retiredCount !== 16'd0) begin
            tests_failed++; $display("FAIL midreset_release got rdy=%0b cnt=%0d exp rdy=1 cnt=0", inReady, retiredCount);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (vrfWe === 1'b1) seen = 1'b1;
            step;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL midreset_no_lanes got write=1 exp write=0"); end
        $display("[TB] reset mid-vector aborted");
    endtask

    task automatic test_count_wrap;
        bufferIn = mk(1'b0, 1'b0, 1'b0, 4'd0, 144'd0, 144'd0);
        inValid = 1'b1;
        repeat (65535) step;
        tests_run++;
        if (retiredCount !== 16'hFFFF) begin tests_failed++; $display("FAIL count_max got=%h exp=ffff", retiredCount); end
        step;
        inValid = 1'b0;
        tests_run++;
        if (retiredCount !== 16'h0000 || rfWe !== 1'b0) begin
            tests_failed++; $display("FAIL count_wrap got cnt=%h rfwe=%0b exp cnt=0000 rfwe=0", retiredCount, rfWe);
        end
        $display("[TB] retire counter wrap cnt=%h", retiredCount);
    endtask

    initial begin
        test_reset;
        test_scalar_alu;
        test_back_to_back;
        test_vector;
        test_stall;
        test_both_flags_and_store;
        test_reset_mid_vector;
        test_count_wrap;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
